// File: rtl/flash_stream_ctrl.sv
// flash_stream_ctrl
// Sequences SPI flash READ bursts that stream pixel bits straight into a
// 1-bit FIFO write port. A burst ends when the FIFO fills or streaming is
// paused, and the next burst resumes at the exact next bit by re-addressing
// the interrupted byte and discarding the bits already delivered.
module flash_stream_ctrl #(
    parameter int                ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 24'h000000,
    parameter int                FRAME_BITS = 172800,
    parameter int                NUM_FRAMES = 6572,
    parameter int                MIN_GAP    = 4,
    parameter logic [7:0]        READ_CMD   = 8'h03
) (
    input  logic        write_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fifo_full,
    output logic        fifo_write_en,
    output logic        fifo_din,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        frame_done,
    output logic [15:0] frame_idx,
    output logic        busy,
    output logic        done
);

    localparam int FB_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int CNT_W = $clog2(ADDR_W);

    localparam logic [FB_W-1:0]  LAST_BIT   = FB_W'(FRAME_BITS - 1);
    localparam logic [15:0]      LAST_FRAME = 16'(NUM_FRAMES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [ADDR_W-1:0]  rd_addr;       // byte address of the byte currently on MISO
    logic [2:0]         skip;          // leading bits of the burst to discard
    logic [2:0]         bit_pos;       // bit position within the current byte
    logic [FB_W-1:0]    bit_in_frame;
    logic [GAP_W-1:0]   gap_cnt;
    logic [CNT_W-1:0]   hdr_cnt;       // bit counter for command and address
    logic [ADDR_W-1:0]  hdr_sr;        // remaining header bits, MSB goes out next
    logic               pause;

    assign fifo_din = spi_miso;
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign done     = (state == S_DONE);

    // Next-state decode plus the combinational FIFO strobe and frame pulse
    always_comb begin
        state_nxt     = state;
        fifo_write_en = 1'b0;
        frame_done    = 1'b0;
        pause         = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !fifo_full) state_nxt = S_CMD;
            end
            S_CMD: begin
                if (hdr_cnt == CMD_LAST) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (hdr_cnt == ADDR_LAST) state_nxt = S_DATA;
            end
            S_DATA: begin
                // Discarded bits never write, so a full FIFO is irrelevant to them
                if (skip == 3'd0) begin
                    if (fifo_full || !enable) begin
                        pause     = 1'b1;
                        state_nxt = S_GAP;
                    end else begin
                        fifo_write_en = 1'b1;
                        if (bit_in_frame == LAST_BIT) begin
                            frame_done = 1'b1;
                            if (frame_idx == LAST_FRAME) state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_GAP: begin
                if ((gap_cnt == GAP_LAST) && enable && !fifo_full) state_nxt = S_CMD;
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge write_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Chip select follows the next state; MOSI shifts out command then address
    always_ff @(posedge write_clk) begin
        if (reset) begin
            spi_cs_n <= 1'b1;
            spi_mosi <= 1'b0;
            hdr_cnt  <= '0;
            hdr_sr   <= '0;
        end else begin
            spi_cs_n <= !(state_nxt inside {S_CMD, S_ADDR, S_DATA});
            case (state)
                S_IDLE, S_GAP: begin
                    if (state_nxt == S_CMD) begin
                        spi_mosi <= READ_CMD[7];
                        hdr_sr   <= {READ_CMD[6:0], {(ADDR_W-7){1'b0}}};
                        hdr_cnt  <= '0;
                    end else begin
                        spi_mosi <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (hdr_cnt == CMD_LAST) begin
                        spi_mosi <= rd_addr[ADDR_W-1];
                        hdr_sr   <= {rd_addr[ADDR_W-2:0], 1'b0};
                        hdr_cnt  <= '0;
                    end else begin
                        spi_mosi <= hdr_sr[ADDR_W-1];
                        hdr_sr   <= {hdr_sr[ADDR_W-2:0], 1'b0};
                        hdr_cnt  <= hdr_cnt + CNT_W'(1);
                    end
                end
                S_ADDR: begin
                    if (hdr_cnt == ADDR_LAST) begin
                        spi_mosi <= 1'b0;
                        hdr_cnt  <= '0;
                    end else begin
                        spi_mosi <= hdr_sr[ADDR_W-1];
                        hdr_sr   <= {hdr_sr[ADDR_W-2:0], 1'b0};
                        hdr_cnt  <= hdr_cnt + CNT_W'(1);
                    end
                end
                default: spi_mosi <= 1'b0;
            endcase
        end
    end

    // Byte address, bit position and discard count; a pause rewinds to the current byte
    always_ff @(posedge write_clk) begin
        if (reset) begin
            rd_addr <= BASE_ADDR;
            skip    <= 3'd0;
            bit_pos <= 3'd0;
        end else if ((state == S_ADDR) && (state_nxt == S_DATA)) begin
            bit_pos <= 3'd0;
        end else if (state == S_DATA) begin
            if (pause) begin
                // rd_addr already names the interrupted byte
                skip <= bit_pos;
            end else begin
                bit_pos <= bit_pos + 3'd1;
                if (bit_pos == 3'd7) rd_addr <= rd_addr + ADDR_W'(1);
                if (skip != 3'd0)    skip    <= skip - 3'd1;
            end
        end
    end

    // Frame position; the last frame index is held once the final frame completes
    always_ff @(posedge write_clk) begin
        if (reset) begin
            bit_in_frame <= '0;
            frame_idx    <= 16'd0;
        end else if (fifo_write_en) begin
            if (frame_done) begin
                bit_in_frame <= '0;
                if (frame_idx != LAST_FRAME) frame_idx <= frame_idx + 16'd1;
            end else begin
                bit_in_frame <= bit_in_frame + FB_W'(1);
            end
        end
    end

    // Inter-burst gap timer, restarted on every entry to GAP
    always_ff @(posedge write_clk) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if ((state != S_GAP) && (state_nxt == S_GAP)) begin
            gap_cnt <= '0;
        end else if ((state == S_GAP) && (gap_cnt != GAP_LAST)) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_flash_stream_ctrl.sv
// Testbench for flash_stream_ctrl: two instances (16-bit single frame and
// 12-bit three-frame configurations) each attached to a behavioural SPI flash
// holding a small byte image. The expected FIFO stream is simply the image
// read bit-serially from BASE_ADDR, independent of burst boundaries.
module tb_flash_stream_ctrl;

    localparam int          FB0  = 16;
    localparam int          NF0  = 1;
    localparam int          FB1  = 12;
    localparam int          NF1  = 3;
    localparam logic [23:0] BASE = 24'h000100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        en    [2];
    logic        full  [2];
    logic        we    [2];
    logic        din   [2];
    logic        cs_n  [2];
    logic        mosi  [2];
    logic        miso  [2];
    logic        fdone [2];
    logic        busy  [2];
    logic        done  [2];
    logic [15:0] fidx  [2];

    flash_stream_ctrl #(
        .ADDR_W(24), .BASE_ADDR(BASE), .FRAME_BITS(FB0), .NUM_FRAMES(NF0),
        .MIN_GAP(4), .READ_CMD(8'h03)
    ) dut_a (
        .write_clk(clk), .reset(rst[0]), .enable(en[0]), .fifo_full(full[0]),
        .fifo_write_en(we[0]), .fifo_din(din[0]), .spi_cs_n(cs_n[0]),
        .spi_mosi(mosi[0]), .spi_miso(miso[0]), .frame_done(fdone[0]),
        .frame_idx(fidx[0]), .busy(busy[0]), .done(done[0])
    );

    flash_stream_ctrl #(
        .ADDR_W(24), .BASE_ADDR(BASE), .FRAME_BITS(FB1), .NUM_FRAMES(NF1),
        .MIN_GAP(4), .READ_CMD(8'h03)
    ) dut_b (
        .write_clk(clk), .reset(rst[1]), .enable(en[1]), .fifo_full(full[1]),
        .fifo_write_en(we[1]), .fifo_din(din[1]), .spi_cs_n(cs_n[1]),
        .spi_mosi(mosi[1]), .spi_miso(miso[1]), .frame_done(fdone[1]),
        .frame_idx(fidx[1]), .busy(busy[1]), .done(done[1])
    );

    // Flash image starting at byte address 0x100
    logic [7:0] mem_img [0:7] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h96, 8'h0F, 8'hF0, 8'h81};

    function automatic logic membit(input int a);
        int         idx;
        logic [2:0] bp;
        logic [7:0] b;
        idx = a / 8 - 'h100;
        bp  = 3'(a % 8);
        if (idx < 0 || idx > 7) return 1'b0;
        b = mem_img[idx];
        return b[3'd7 - bp];
    endfunction

    function automatic int fb_of(input int i);
        return (i == 0) ? FB0 : FB1;
    endfunction

    function automatic int nf_of(input int i);
        return (i == 0) ? NF0 : NF1;
    endfunction

    // Behavioural SPI flash: collects a 32-bit header while selected, then
    // presents successive bits of the image from the received byte address.
    int          hcnt    [2];
    logic [30:0] hsr     [2];
    int          ptr     [2];
    logic [31:0] hdr_log [2][8];
    int          hdr_n   [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) hdr_n[i] <= 0;
            if (cs_n[i]) begin
                hcnt[i] <= 0;
            end else if (hcnt[i] < 32) begin
                hsr[i]  <= {hsr[i][29:0], mosi[i]};
                hcnt[i] <= hcnt[i] + 1;
                if (hcnt[i] == 31) begin
                    ptr[i] <= int'({hsr[i][22:0], mosi[i]}) * 8;
                    if (!rst[i] && hdr_n[i] < 8) begin
                        hdr_log[i][hdr_n[i]] <= {hsr[i], mosi[i]};
                        hdr_n[i] <= hdr_n[i] + 1;
                    end
                end
            end else begin
                ptr[i] <= ptr[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            miso[i] = (hcnt[i] == 32) ? membit(ptr[i]) : 1'b0;
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_cnt  [2];
    logic [63:0] bits    [2];
    int          fd_n    [2];
    int          fd_pos  [2][4];
    int          hdr_chk [2];

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int c;
        c = 0;
        while (!done[i] && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("done_reached", i, 64'(done[i]), 64'd1);
    endtask

    task automatic wait_wr(input int i, input int n, input int budget);
        int c;
        c = 0;
        while (wr_cnt[i] != n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("write_count_reached", i, 64'(wr_cnt[i]), 64'(n));
    endtask

    task automatic wait_hcnt(input int i, input int n, input int budget);
        int c;
        c = 0;
        while (hcnt[i] != n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("header_bit_reached", i, 64'(hcnt[i]), 64'(n));
    endtask

    task automatic chk_stream16(input string nm);
        chk({nm, "_bits"}, 0, 64'(bits[0][15:0]), 64'h0000_0000_0000_A53C);
        chk({nm, "_writes"}, 0, 64'(wr_cnt[0]), 64'd16);
        chk({nm, "_frame_pulses"}, 0, 64'(fd_n[0]), 64'd1);
        chk({nm, "_cs_n_done"}, 0, 64'(cs_n[0]), 64'd1);
    endtask

    initial begin
        rst  = '{1'b1, 1'b1};
        en   = '{1'b0, 1'b0};
        full = '{1'b0, 1'b0};
        fork
            // Per-cycle compare against the bit-serial image model
            forever begin
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    if (rst[i]) begin
                        wr_cnt[i]  = 0;
                        bits[i]    = '0;
                        fd_n[i]    = 0;
                        hdr_chk[i] = 0;
                    end else begin
                        if (we[i]) begin
                            chk("din", i, 64'(din[i]), 64'(membit(int'(BASE) * 8 + wr_cnt[i])));
                            chk("write_while_full", i, 64'(full[i]), 64'd0);
                            chk("frame_done", i, 64'(fdone[i]),
                                64'((wr_cnt[i] % fb_of(i)) == fb_of(i) - 1));
                            chk("frame_idx", i, 64'(fidx[i]), 64'(wr_cnt[i] / fb_of(i)));
                            bits[i] = {bits[i][62:0], din[i]};
                            if (fdone[i] && fd_n[i] < 4) begin
                                fd_pos[i][fd_n[i]] = wr_cnt[i] + 1;
                                fd_n[i]++;
                            end
                            wr_cnt[i]++;
                        end else begin
                            chk("frame_done_without_write", i, 64'(fdone[i]), 64'd0);
                        end
                        if (done[i]) begin
                            chk("done_cs_n", i, 64'(cs_n[i]), 64'd1);
                            chk("done_busy", i, 64'(busy[i]), 64'd0);
                            chk("done_writes", i, 64'(wr_cnt[i]), 64'(fb_of(i) * nf_of(i)));
                        end
                        while (hdr_chk[i] < hdr_n[i]) begin
                            chk("header", i, 64'(hdr_log[i][hdr_chk[i]]),
                                64'({8'h03, BASE + 24'(wr_cnt[i] / 8)}));
                            hdr_chk[i]++;
                        end
                    end
                end
            end
            begin
                // Reset state
                repeat (3) @(posedge clk);
                #1;
                chk("rst_cs_n", 0, 64'(cs_n[0]), 64'd1);
                chk("rst_mosi", 0, 64'(mosi[0]), 64'd0);
                chk("rst_we", 0, 64'(we[0]), 64'd0);
                chk("rst_frame_done", 0, 64'(fdone[0]), 64'd0);
                chk("rst_frame_idx", 0, 64'(fidx[0]), 64'd0);
                chk("rst_busy", 0, 64'(busy[0]), 64'd0);
                chk("rst_done", 0, 64'(done[0]), 64'd0);
                rst[0] = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("idle_disabled_cs_n", 0, 64'(cs_n[0]), 64'd1);

                // Single uninterrupted frame
                do_reset(0);
                en[0] = 1'b1;
                wait_done(0, 200);
                chk_stream16("plain");
                chk("plain_headers", 0, 64'(hdr_n[0]), 64'd1);
                chk("plain_hdr0", 0, 64'(hdr_log[0][0]), 64'h0300_0100);
                chk("plain_frame_pos", 0, 64'(fd_pos[0][0]), 64'd16);
                chk("plain_frame_idx", 0, 64'(fidx[0]), 64'd0);

                // FIFO full at data bit 11 for 10 cycles
                do_reset(0);
                wait_wr(0, 11, 200);
                full[0] = 1'b1;
                @(posedge clk);
                #1;
                chk("full_cs_n_high", 0, 64'(cs_n[0]), 64'd1);
                chk("full_writes_held", 0, 64'(wr_cnt[0]), 64'd11);
                repeat (9) @(posedge clk);
                #1;
                full[0] = 1'b0;
                wait_done(0, 200);
                chk_stream16("full");
                chk("full_headers", 0, 64'(hdr_n[0]), 64'd2);
                chk("full_hdr1", 0, 64'(hdr_log[0][1]), 64'h0300_0101);

                // Three 12-bit frames in a single burst
                do_reset(1);
                en[1] = 1'b1;
                wait_done(1, 300);
                chk("frames_bits", 1, 64'(bits[1][35:0]), 64'h0000_000A_53C5_AC39);
                chk("frames_pulses", 1, 64'(fd_n[1]), 64'd3);
                chk("frames_pos0", 1, 64'(fd_pos[1][0]), 64'd12);
                chk("frames_pos1", 1, 64'(fd_pos[1][1]), 64'd24);
                chk("frames_pos2", 1, 64'(fd_pos[1][2]), 64'd36);
                chk("frames_headers", 1, 64'(hdr_n[1]), 64'd1);
                chk("frames_idx_final", 1, 64'(fidx[1]), 64'd2);

                // enable low for 5 cycles at bit 5 of byte 0
                do_reset(0);
                wait_wr(0, 5, 200);
                en[0] = 1'b0;
                @(posedge clk);
                #1;
                chk("pause_cs_n_high", 0, 64'(cs_n[0]), 64'd1);
                repeat (4) @(posedge clk);
                #1;
                en[0] = 1'b1;
                wait_done(0, 200);
                chk_stream16("pause");
                chk("pause_headers", 0, 64'(hdr_n[0]), 64'd2);
                chk("pause_hdr1", 0, 64'(hdr_log[0][1]), 64'h0300_0100);

                // Reset during the address phase
                do_reset(0);
                wait_hcnt(0, 12, 100);
                rst[0] = 1'b1;
                @(posedge clk);
                #1;
                chk("midrst_cs_n", 0, 64'(cs_n[0]), 64'd1);
                chk("midrst_mosi", 0, 64'(mosi[0]), 64'd0);
                chk("midrst_we", 0, 64'(we[0]), 64'd0);
                chk("midrst_frame_idx", 0, 64'(fidx[0]), 64'd0);
                chk("midrst_busy", 0, 64'(busy[0]), 64'd0);
                chk("midrst_done", 0, 64'(done[0]), 64'd0);
                rst[0] = 1'b0;
                wait_done(0, 200);
                chk_stream16("midrst");
                chk("midrst_headers", 0, 64'(hdr_n[0]), 64'd1);
                chk("midrst_hdr0", 0, 64'(hdr_log[0][0]), 64'h0300_0100);

                // FIFO full while idle holds off the burst
                full[0] = 1'b1;
                do_reset(0);
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    chk("idle_full_cs_n", 0, 64'(cs_n[0]), 64'd1);
                    chk("idle_full_busy", 0, 64'(busy[0]), 64'd0);
                end
                full[0] = 1'b0;
                @(posedge clk);
                #1;
                chk("idle_release_cs_n", 0, 64'(cs_n[0]), 64'd0);
                chk("idle_release_busy", 0, 64'(busy[0]), 64'd1);
                chk("idle_release_mosi", 0, 64'(mosi[0]), 64'd0);
                wait_done(0, 200);
                chk_stream16("idle_full");

                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        join
    end

endmodule
